// File: rtl/text_display_pkg.sv
// Shared constants, FSM state type and tile address helper for the text display.
package text_display_pkg;

    localparam int unsigned COLS   = 160;
    localparam int unsigned ROWS   = 45;
    localparam int unsigned TILE_W = 8;
    localparam int unsigned TILE_H = 16;
    localparam int unsigned ADDR_W = 14;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Row occupies the upper bits so each row starts on a 256-entry boundary.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] row, input logic [7:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_tile_writer.sv
// ASCII stream to tile BRAM writer with text cursor, control codes and button moves.
// Build option CLEAR_ON_RESET_EN: reset enters a full-screen BLANK sweep instead of IDLE.
module text_tile_writer
    import text_display_pkg::*;
#(
    parameter logic [7:0] BLANK = ASCII_SPACE
) (
    input  logic              clk_75mhz,
    input  logic              rst_sync,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic [3:0]        move_pulse,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic [7:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic [15:0]       cursor_x_px,
    output logic [15:0]       cursor_y_px,
    output logic              busy
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
`ifdef CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    logic [7:0]        col, col_n, sweep_col;
    logic [5:0]        row, row_n, sweep_row;
    logic              sweep_done;
    logic              accept, do_write, start_clear;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    assign char_ready  = (state == IDLE);
    assign busy        = (state == CLEAR);
    assign accept      = char_valid && char_ready;
    assign cursor_col  = col;
    assign cursor_row  = row;
    assign cursor_x_px = {5'b0, col, 3'b0};
    assign cursor_y_px = {6'b0, row, 4'b0};

    always_comb begin
        col_n       = col;
        row_n       = row;
        do_write    = 1'b0;
        start_clear = 1'b0;
        wr_addr     = tile_addr(row, col);
        wr_data     = char_data;
        if (accept) begin
            if (char_data >= ASCII_SPACE && char_data <= 8'h7E) begin
                do_write = 1'b1;
                if (col == LAST_COL) begin
                    col_n = '0;
                    row_n = (row == LAST_ROW) ? '0 : row + 6'd1;
                end else begin
                    col_n = col + 8'd1;
                end
            end else begin
                case (char_data)
                    ASCII_CR: col_n = '0;
                    ASCII_LF: begin
                        col_n = '0;
                        row_n = (row == LAST_ROW) ? '0 : row + 6'd1;
                    end
                    ASCII_BS: begin
                        // Backspace blanks the tile the cursor lands on, not the one it leaves.
                        wr_data = BLANK;
                        if (col != '0) begin
                            col_n    = col - 8'd1;
                            do_write = 1'b1;
                        end else if (row != '0) begin
                            row_n    = row - 6'd1;
                            col_n    = LAST_COL;
                            do_write = 1'b1;
                        end
                        wr_addr = tile_addr(row_n, col_n);
                    end
                    ASCII_FF: start_clear = 1'b1;
                    default: ;
                endcase
            end
        end else if (state == IDLE && $onehot(move_pulse)) begin
            case (move_pulse)
                4'b1000: if (row != '0)       row_n = row - 6'd1;
                4'b0100: if (row != LAST_ROW) row_n = row + 6'd1;
                4'b0010: if (col != '0)       col_n = col - 8'd1;
                4'b0001: if (col != LAST_COL) col_n = col + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_75mhz or posedge rst_sync) begin
        if (rst_sync) begin
            state      <= RESET_STATE;
            col        <= '0;
            row        <= '0;
            sweep_col  <= '0;
            sweep_row  <= '0;
            sweep_done <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bram_we <= do_write;
                    if (do_write) begin
                        bram_addr  <= wr_addr;
                        bram_wdata <= wr_data;
                    end
                    col <= col_n;
                    row <= row_n;
                    if (start_clear) begin
                        state      <= CLEAR;
                        col        <= '0;
                        row        <= '0;
                        sweep_col  <= '0;
                        sweep_row  <= '0;
                        sweep_done <= 1'b0;
                    end else if (accept) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    bram_we <= 1'b0;
                    state   <= IDLE;
                end
                CLEAR: begin
                    // Stay one extra cycle after the last write so busy covers it.
                    if (sweep_done) begin
                        bram_we <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bram_we    <= 1'b1;
                        bram_addr  <= tile_addr(sweep_row, sweep_col);
                        bram_wdata <= BLANK;
                        if (sweep_col == LAST_COL) begin
                            sweep_col <= '0;
                            if (sweep_row == LAST_ROW) sweep_done <= 1'b1;
                            else                       sweep_row  <= sweep_row + 6'd1;
                        end else begin
                            sweep_col <= sweep_col + 8'd1;
                        end
                    end
                end
                default: begin
                    bram_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_tile_writer.sv
// Self-checking bench for text_tile_writer: directed table, random stream vs. cursor model, clear sweeps.
module tb_text_tile_writer;

    logic        clk_75mhz = 1'b0;
    logic        rst_sync = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [3:0]  move_pulse = 4'b0000;
    logic        bram_we;
    logic [13:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic [7:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [15:0] cursor_x_px;
    logic [15:0] cursor_y_px;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int m_pos = 0;  // model cursor as linear tile index row*160+col

    always #5 clk_75mhz = ~clk_75mhz;

    text_tile_writer dut (
        .clk_75mhz  (clk_75mhz),
        .rst_sync   (rst_sync),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .move_pulse (move_pulse),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .cursor_x_px(cursor_x_px),
        .cursor_y_px(cursor_y_px),
        .busy       (busy)
    );

    typedef struct {
        string      name;
        int         sc;
        int         sr;
        bit         is_byte;
        logic [7:0] b;
        logic [3:0] mv;
        bit         we;
        int         addr;
        int         wd;
        int         ec;
        int         er;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (char_ready !== 1'b1 && n < limit) begin
            @(negedge clk_75mhz);
            n++;
        end
        if (char_ready !== 1'b1) check("ready_timeout", 32'(char_ready), 1);
    endtask

    task automatic pulse_move(input logic [3:0] m);
        move_pulse = m;
        @(negedge clk_75mhz);
        move_pulse = 4'b0000;
    endtask

    task automatic goto_tile(input int c, input int r);
        wait_ready(10000);
        for (int i = 0; i < 45; i++)  pulse_move(4'b1000);
        for (int i = 0; i < 160; i++) pulse_move(4'b0010);
        for (int i = 0; i < c; i++)   pulse_move(4'b0001);
        for (int i = 0; i < r; i++)   pulse_move(4'b0100);
        m_pos = r * 160 + c;
    endtask

    // Reference: cursor as a linear index; addresses rebuilt as row*256+col.
    task automatic model_apply(input bit is_byte, input logic [7:0] b, input logic [3:0] mv,
                               output bit we, output int addr, output int wd);
        int r, c;
        we = 0; addr = 0; wd = 0;
        r = m_pos / 160;
        c = m_pos % 160;
        if (is_byte) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                we = 1; addr = r * 256 + c; wd = int'(b);
                m_pos = (m_pos + 1) % 7200;
            end else if (b == 8'h0D) begin
                m_pos = r * 160;
            end else if (b == 8'h0A) begin
                m_pos = ((r + 1) % 45) * 160;
            end else if (b == 8'h08 && m_pos > 0) begin
                m_pos = m_pos - 1;
                we = 1; addr = (m_pos / 160) * 256 + (m_pos % 160); wd = 32'h20;
            end
        end else if ($countones(mv) == 1) begin
            if (mv[3] && r > 0)        m_pos = m_pos - 160;
            else if (mv[2] && r < 44)  m_pos = m_pos + 160;
            else if (mv[1] && c > 0)   m_pos = m_pos - 1;
            else if (mv[0] && c < 159) m_pos = m_pos + 1;
        end
    endtask

    task automatic apply_op(input string name, input bit is_byte, input logic [7:0] b, input logic [3:0] mv,
                            input bit we, input int addr, input int wd, input int ec, input int er);
        wait_ready(10000);
        char_valid = is_byte;
        char_data  = b;
        move_pulse = mv;
        @(negedge clk_75mhz);
        char_valid = 1'b0;
        move_pulse = 4'b0000;
        check({name, "_we"}, 32'(bram_we), 32'(we));
        if (we) begin
            check({name, "_addr"}, 32'(bram_addr), addr);
            check({name, "_wdata"}, 32'(bram_wdata), wd);
        end
        check({name, "_col"}, 32'(cursor_col), ec);
        check({name, "_row"}, 32'(cursor_row), er);
    endtask

    task automatic send_ff();
        wait_ready(10000);
        char_valid = 1'b1;
        char_data  = 8'h0C;
        @(negedge clk_75mhz);
        char_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   we;
        int   addr, wd, sel, n, wcount, bad_col, bad_data, dup, busy_low;
        logic [7:0] b;
        logic [3:0] mv;
        bit   seen [0:16383];

        vecs[0]  = '{"wrap_col",   159, 0,  1, 8'h42, 4'h0, 1, 'h009F, 'h42, 0,   1};
        vecs[1]  = '{"wrap_grid",  159, 44, 1, 8'h43, 4'h0, 1, 'h2C9F, 'h43, 0,   0};
        vecs[2]  = '{"bs_rowback", 0,   1,  1, 8'h08, 4'h0, 1, 'h009F, 'h20, 159, 0};
        vecs[3]  = '{"bs_origin",  0,   0,  1, 8'h08, 4'h0, 0, 0,      0,    0,   0};
        vecs[4]  = '{"cr",         5,   3,  1, 8'h0D, 4'h0, 0, 0,      0,    0,   3};
        vecs[5]  = '{"lf_wrap",    5,   44, 1, 8'h0A, 4'h0, 0, 0,      0,    0,   0};
        vecs[6]  = '{"drop_7f",    5,   3,  1, 8'h7F, 4'h0, 0, 0,      0,    5,   3};
        vecs[7]  = '{"tilde",      5,   3,  1, 8'h7E, 4'h0, 1, 'h0305, 'h7E, 6,   3};
        vecs[8]  = '{"mv_up",      5,   3,  0, 8'h00, 4'h8, 0, 0,      0,    5,   2};
        vecs[9]  = '{"mv_up_sat",  5,   0,  0, 8'h00, 4'h8, 0, 0,      0,    5,   0};
        vecs[10] = '{"mv_rt_sat",  159, 7,  0, 8'h00, 4'h1, 0, 0,      0,    159, 7};
        vecs[11] = '{"mv_lt_sat",  0,   7,  0, 8'h00, 4'h2, 0, 0,      0,    0,   7};
        vecs[12] = '{"mv_dn_sat",  5,   44, 0, 8'h00, 4'h4, 0, 0,      0,    5,   44};
        vecs[13] = '{"mv_multi",   5,   3,  0, 8'h00, 4'h3, 0, 0,      0,    5,   3};

        // Reset state
        repeat (3) @(negedge clk_75mhz);
        check("rst_we", 32'(bram_we), 0);
        check("rst_addr", 32'(bram_addr), 0);
        check("rst_wdata", 32'(bram_wdata), 0);
        check("rst_col", 32'(cursor_col), 0);
        check("rst_row", 32'(cursor_row), 0);
`ifdef CLEAR_ON_RESET_EN
        check("rst_busy", 32'(busy), 1);
        rst_sync = 1'b0;
        n = 0;
        while (char_ready !== 1'b1 && n < 8000) begin
            @(negedge clk_75mhz);
            n++;
        end
        check("por_clear_cycles", n, 7201);
`else
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(char_ready), 1);
        rst_sync = 1'b0;
        @(negedge clk_75mhz);
`endif

        // First character
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(negedge clk_75mhz);
        char_valid = 1'b0;
        check("a_we", 32'(bram_we), 1);
        check("a_addr", 32'(bram_addr), 0);
        check("a_wdata", 32'(bram_wdata), 'h41);
        check("a_col", 32'(cursor_col), 1);
        check("a_xpx", 32'(cursor_x_px), 8);
        check("a_ready_low", 32'(char_ready), 0);
        @(negedge clk_75mhz);
        check("a_we_drop", 32'(bram_we), 0);
        check("a_ready_back", 32'(char_ready), 1);

        foreach (vecs[i]) begin
            goto_tile(vecs[i].sc, vecs[i].sr);
            apply_op(vecs[i].name, vecs[i].is_byte, vecs[i].b, vecs[i].mv,
                     vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].ec, vecs[i].er);
        end

        // Byte and move in the same cycle: move dropped; move during WRITE also dropped
        goto_tile(5, 3);
        apply_op("byte_with_move", 1, 8'h78, 4'b0001, 1, 'h0305, 'h78, 6, 3);
        pulse_move(4'b0001);
        wait_ready(10);
        check("move_in_write_col", 32'(cursor_col), 6);

        // Random stream against the model
        goto_tile(0, 0);
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            mv  = 4'($urandom_range(0, 15));
            case (sel)
                0, 1, 2, 3: b = 8'($urandom_range(32, 126));
                4:          b = 8'h0D;
                5:          b = 8'h0A;
                6, 7:       b = 8'h08;
                8:          b = 8'($urandom_range(127, 255));
                default:    b = 8'h00;
            endcase
            model_apply(sel != 9, b, mv, we, addr, wd);
            apply_op("rand", sel != 9, b, mv, we, addr, wd, m_pos % 160, m_pos / 160);
            check("rand_xpx", 32'(cursor_x_px), (m_pos % 160) * 8);
            check("rand_ypx", 32'(cursor_y_px), (m_pos / 160) * 16);
        end

        // Full clear sweep
        foreach (seen[i]) seen[i] = 1'b0;
        send_ff();
        n = 0; wcount = 0; bad_col = 0; bad_data = 0; dup = 0; busy_low = 0;
        while (char_ready !== 1'b1 && n < 8000) begin
            if (bram_we) begin
                wcount++;
                if (bram_addr[7:0] >= 8'd160) bad_col++;
                if (bram_wdata != 8'h20) bad_data++;
                if (seen[bram_addr]) dup++;
                seen[bram_addr] = 1'b1;
            end
            if (!busy) busy_low++;
            @(negedge clk_75mhz);
            n++;
        end
        check("ff_writes", wcount, 7200);
        check("ff_bad_col", bad_col, 0);
        check("ff_bad_data", bad_data, 0);
        check("ff_dup_addr", dup, 0);
        check("ff_busy_low", busy_low, 0);
        check("ff_cycles", n, 7201);
        check("ff_ready", 32'(char_ready), 1);
        check("ff_busy_end", 32'(busy), 0);
        check("ff_col", 32'(cursor_col), 0);
        check("ff_row", 32'(cursor_row), 0);

        // Reset during a clear sweep
        goto_tile(9, 4);
        send_ff();
        n = 0; wcount = 0;
        while (wcount < 100 && n < 500) begin
            @(negedge clk_75mhz);
            if (bram_we) wcount++;
            n++;
        end
        check("abort_reached_100", wcount, 100);
        rst_sync = 1'b1;
        @(negedge clk_75mhz);
        check("abort_we", 32'(bram_we), 0);
        check("abort_addr", 32'(bram_addr), 0);
        check("abort_col", 32'(cursor_col), 0);
        check("abort_row", 32'(cursor_row), 0);
`ifdef CLEAR_ON_RESET_EN
        check("abort_busy", 32'(busy), 1);
        rst_sync = 1'b0;
        wait_ready(8000);
`else
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(char_ready), 1);
        rst_sync = 1'b0;
`endif
        @(negedge clk_75mhz);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
